spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

- Sits directly downstream of the 6809 address decoder and consumes its SPI-flash chip-select output.
- On a CPU read inside the flash window, it runs one SPI mode-0 READ transaction to the external flash. It holds the CPU via `o_mrdy` until the byte is available, then presents the byte on `o_data`.
- Writes into the flash window are ignored.
- It drives the flash pins only while a transaction is in flight, so the FT2232 can share the bus.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCK half-period in `i_clk` cycles; legal range ≥1.
- `FLASH_OFFSET`, default 24'h000000: base flash byte address mapped to CPU window offset 0.

Ports:
- `i_clk`, input, 1: system clock. Single clock domain.
- `i_reset_n`, input, 1: reset, synchronous, active-low.
- `i_spi_ce`, input, 1: flash-window select from the address decoder. Already qualified by the FT2232 chip-select.
- `i_rw`, input, 1: 6809 R/W (1 = read).
- `i_address`, input, 16: CPU address bus.
- `i_spi_miso`, input, 1: flash serial data out.
- `o_data`, output, 8: last byte read; holds until the next read completes.
- `o_data_valid`, output, 1: one-cycle pulse when `o_data` updates.
- `o_mrdy`, output, 1: CPU ready (0 = stretch the bus cycle).
- `o_spi_cs_n`, output, 1: flash chip select, active-low.
- `o_spi_sck`, output, 1: SPI clock, idle low.
- `o_spi_mosi`, output, 1: SPI data to the flash.
- `o_spi_oe`, output, 1: pin output enable; 1 while driving CS/SCK/MOSI.

## Operation
- **States:** IDLE, CMD, ADDR, (DUMMY), DATA, DONE, RELEASE.
- **IDLE:**
  - Request condition: `i_spi_ce`=1 and `i_rw`=1, sampled on a clock edge.
  - On request: latch flash address = `FLASH_OFFSET` + {12'h000, `i_address[11:0]`}, modulo 2^24 (24-bit wrap).
  - Drop `o_mrdy` combinationally with the request so the CPU is stretched in the same cycle. Next state is CMD.
  - `i_spi_ce`=1 with `i_rw`=0 is ignored; `o_mrdy` stays 1.
- **CMD:** shift opcode 8'h03, MSB first.
- **ADDR:** shift the 24 address bits, MSB first.
- **DATA:** shift in 8 bits, MSB first. `o_spi_mosi` is held 0.
- **SPI mode 0:**
  - MOSI changes while SCK is low; MISO is sampled on the SCK rising edge.
  - Each SCK phase lasts exactly `CLK_DIV` clocks.
- **DONE** (one cycle):
  - `o_spi_cs_n`=1, `o_data` updated, `o_data_valid`=1, `o_mrdy`=1.
  - Next state is RELEASE.
- **RELEASE:**
  - Wait for `i_spi_ce`=0, then go to IDLE.
  - This prevents re-issuing the transfer for the same, still-asserted CPU cycle.
  - `o_mrdy`=1 throughout.
- **Output enable:** `o_spi_oe`=1 only in CMD/ADDR/DUMMY/DATA. Otherwise 0 and the pins are released to the FT2232.
- **`i_spi_ce` drops mid-transfer** (e.g. FT2232 takes over): the transaction still completes; the data is latched and `o_data_valid` pulses.
- **Reset mid-transfer:** all outputs return to reset values on the next edge; the transfer is aborted with no `o_data_valid`.

## Timing
- **Reset values:**
  - `o_spi_cs_n`=1, `o_spi_sck`=0, `o_spi_mosi`=0, `o_spi_oe`=0.
  - `o_data`=8'h00, `o_data_valid`=0, `o_mrdy`=1.
- **Request to first bit:**
  - Request sampled at edge T. At T+1: `o_spi_cs_n`=0, `o_spi_oe`=1, MOSI = opcode bit 7, SCK=0.
  - First SCK rise at T+1+`CLK_DIV`.
- **Transfer length:** 32 SCK periods (8 cmd + 24 addr); plus 8 more for the data byte, giving 40 SCK periods total.
- **Read latency:** `o_data_valid` at T+1+80·`CLK_DIV`; 161 clocks for `CLK_DIV`=2.
- **Bus release:** `o_spi_cs_n` deasserts in the DONE cycle. SCK is already low at the end of the last SCK period.
- **Back-to-back reads:** minimum gap of one IDLE cycle after `i_spi_ce` falls.

## Configuration
- Macro: `SPI_FAST_READ_EN`.
- **Defined:**
  - Opcode 8'h0B.
  - A DUMMY state of 8 SCK periods (MOSI=0) is inserted between ADDR and DATA.
  - Latency becomes T+1+96·`CLK_DIV`.
- **Undefined:** opcode 8'h03, no DUMMY state, latency as in Timing.

## Test plan
- **Basic read:**
  - Stimulus: `CLK_DIV`=2, `FLASH_OFFSET`=0, read at `i_address`=16'h2123; flash model returns 8'hA5.
  - Required: MOSI stream 03 00 01 23; `o_data`=8'hA5 with `o_data_valid` at T+161; `o_mrdy` low from T until the DONE cycle.
- **Offset wrap:**
  - Stimulus: `FLASH_OFFSET`=24'hFFFF00, `i_address`=16'h2FFF.
  - Required: address bits shifted out are 24'h000EFF.
- **Write ignored:**
  - Stimulus: `i_spi_ce`=1, `i_rw`=0 for 200 clocks.
  - Required: `o_spi_cs_n` stays 1, `o_mrdy` stays 1, `o_spi_oe` stays 0.
- **Held select:**
  - Stimulus: `i_spi_ce` held 1 for 400 clocks after one read.
  - Required: exactly one transaction and one `o_data_valid` pulse; a second transfer starts only after `i_spi_ce` toggles low then high.
- **Reset mid-transfer:**
  - Stimulus: `i_reset_n`=0 during ADDR.
  - Required: next edge gives `o_spi_cs_n`=1, `o_spi_sck`=0, `o_mrdy`=1, no `o_data_valid`.
- **Fast read:**
  - Stimulus: build with `SPI_FAST_READ_EN`, `CLK_DIV`=1.
  - Required: opcode 0B, 8 dummy clocks, `o_data_valid` at T+97.

Source files
------------

// File: rtl/spi_flash_reader.sv
// Purpose: turns a 6809 read in the flash window into one SPI mode-0 READ and returns the byte on o_data.
// Latency: o_data_valid in cycle T+1+80*CLK_DIV after request cycle T (T+1+96*CLK_DIV with FAST READ).
// Backpressure: o_mrdy stretches the CPU from the request until DONE; SPI pins are released (o_spi_oe=0) when idle.
// Build option: define SPI_FAST_READ_EN for FAST READ (opcode 0B plus 8 dummy SCK periods).
module spi_flash_reader #(
    parameter int unsigned CLK_DIV      = 2,
    parameter logic [23:0] FLASH_OFFSET = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_spi_ce,
    input  logic        i_rw,
    input  logic [15:0] i_address,
    input  logic        i_spi_miso,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_mrdy,
    output logic        o_spi_cs_n,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    output logic        o_spi_oe
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE    = 8'h0B;
    localparam logic       HAS_DUMMY = 1'b1;
`else
    localparam logic [7:0] OPCODE    = 8'h03;
    localparam logic       HAS_DUMMY = 1'b0;
`endif

    // Phase counter must hold CLK_DIV-1; keep it at least one bit wide for CLK_DIV=1.
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    state_t           next_shift;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic [4:0]       bit_q, bit_d;
    logic [4:0]       last_bit;
    logic [31:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       data_q, data_d;

    logic             req;
    logic             shifting;
    logic             phase_end;
    logic [23:0]      flash_addr;
    logic             unused_addr_hi;

    // Only the low 12 address bits select within the window; the decoder already qualified the rest.
    assign flash_addr     = FLASH_OFFSET + {12'h000, i_address[11:0]};
    assign unused_addr_hi = ^i_address[15:12];

    // A request is ignored while reset is held so o_mrdy shows its reset value.
    assign req       = i_reset_n & i_spi_ce & i_rw;
    assign shifting  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       (state_q == S_DUMMY) || (state_q == S_DATA);
    assign phase_end = (div_q == DIV_LAST);

    assign o_spi_cs_n   = ~shifting;
    assign o_spi_oe     = shifting;
    assign o_spi_sck    = sck_q;
    assign o_spi_mosi   = ((state_q == S_CMD) || (state_q == S_ADDR)) ? tx_q[31] : 1'b0;
    assign o_data       = data_q;
    assign o_data_valid = (state_q == S_DONE);
    // Combinational drop so the CPU is stretched in the very cycle it presents the read.
    assign o_mrdy       = ~(shifting | ((state_q == S_IDLE) & req));

    // Number of bits in the current shift state and which state follows it.
    always_comb begin
        last_bit   = 5'd7;
        next_shift = S_DONE;
        case (state_q)
            S_CMD:   next_shift = S_ADDR;
            S_ADDR: begin
                last_bit   = 5'd23;
                next_shift = HAS_DUMMY ? S_DUMMY : S_DATA;
            end
            S_DUMMY: next_shift = S_DATA;
            default: next_shift = S_DONE;
        endcase
    end

    // Next-state logic: SCK phase timing, bit shifting and transaction sequencing.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_CMD;
                    tx_d    = {OPCODE, flash_addr};
                    div_d   = '0;
                    sck_d   = 1'b0;
                    bit_d   = '0;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (phase_end) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: the flash output is stable, capture it.
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[6:0], i_spi_miso};
                        end
                    end else begin
                        // Falling edge: bit period over, present the next MOSI bit.
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                        if (bit_q == last_bit) begin
                            bit_d   = '0;
                            state_d = next_shift;
                            if (state_q == S_DATA) begin
                                data_d = rx_q;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until the CPU cycle that caused this read has ended.
                if (!i_spi_ce) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: random CPU reads against an SPI flash model and a transaction-level reference.
// Expected address, data, latency and pin behaviour are derived from the protocol rules, not from the RTL.
// Covers reset values, writes ignored, held select, mid-transfer select drop, offset wrap and reset mid-transfer.
module tb_spi_flash_reader;

`ifdef SPI_FAST_READ_EN
    localparam int unsigned CLK_DIV       = 1;
    localparam logic [7:0]  EXP_OPCODE    = 8'h0B;
    localparam int          PRE_DATA_BITS = 40;
`else
    localparam int unsigned CLK_DIV       = 2;
    localparam logic [7:0]  EXP_OPCODE    = 8'h03;
    localparam int          PRE_DATA_BITS = 32;
`endif
    localparam logic [23:0] FLASH_OFFSET = 24'hFFFF00;
    localparam int          TOTAL_BITS   = PRE_DATA_BITS + 8;
    // Each SCK period is two phases of CLK_DIV clocks; valid follows the last one.
    localparam int          EXP_LAT      = 1 + 2 * TOTAL_BITS * int'(CLK_DIV);

    logic        i_clk;
    logic        i_reset_n;
    logic        i_spi_ce;
    logic        i_rw;
    logic [15:0] i_address;
    logic        i_spi_miso = 1'b0;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        o_mrdy;
    logic        o_spi_cs_n;
    logic        o_spi_sck;
    logic        o_spi_mosi;
    logic        o_spi_oe;

    int n_cmp = 0;
    int n_bad = 0;

    spi_flash_reader #(
        .CLK_DIV      (CLK_DIV),
        .FLASH_OFFSET (FLASH_OFFSET)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_spi_ce     (i_spi_ce),
        .i_rw         (i_rw),
        .i_address    (i_address),
        .i_spi_miso   (i_spi_miso),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_mrdy       (o_mrdy),
        .o_spi_cs_n   (o_spi_cs_n),
        .o_spi_sck    (o_spi_sck),
        .o_spi_mosi   (o_spi_mosi),
        .o_spi_oe     (o_spi_oe)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Flash contents: a fixed address hash, varied per transaction by salt.
    logic [7:0] salt = 8'h00;
    function automatic logic [7:0] flash_mem(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ salt;
    endfunction

    // SPI flash model: mode 0, samples MOSI on SCK rise, drives MISO after SCK fall.
    logic        fl_sck_prev = 1'b0;
    logic        fl_cs_prev  = 1'b1;
    int          fl_rises    = 0;
    int          fl_txns     = 0;
    int          fl_mosi_bad = 0;
    logic [31:0] fl_hdr      = '0;
    logic [7:0]  fl_byte     = '0;
    always @(o_spi_sck or o_spi_cs_n) begin
        if (fl_cs_prev && !o_spi_cs_n) begin
            fl_txns++;
            fl_rises = 0;
            fl_hdr   = '0;
        end
        if (!o_spi_cs_n) begin
            if (o_spi_sck && !fl_sck_prev) begin
                if (fl_rises < 32) fl_hdr = {fl_hdr[30:0], o_spi_mosi};
                else if (o_spi_mosi !== 1'b0) fl_mosi_bad++;
                fl_rises++;
                if (fl_rises == 32) fl_byte = flash_mem(fl_hdr[23:0]);
            end else if (!o_spi_sck && fl_sck_prev &&
                         fl_rises >= PRE_DATA_BITS && fl_rises < TOTAL_BITS) begin
                i_spi_miso = fl_byte[7 - (fl_rises - PRE_DATA_BITS)];
            end
        end
        fl_sck_prev = o_spi_sck;
        fl_cs_prev  = o_spi_cs_n;
    end

    // One CPU read, called at a negedge; drop_at>0 removes the select mid-transfer,
    // hold is how many cycles the select stays up after the data is delivered.
    task automatic do_read(input logic [15:0] addr, input int drop_at, input int hold);
        int unsigned sum;
        logic [23:0] exp_addr;
        logic [7:0]  exp_data;
        int          n, mrdy_low, first_rise, txns0, extra;
        logic        done;
        sum      = FLASH_OFFSET + (addr % 4096);
        exp_addr = sum[23:0];
        salt     = 8'($urandom);
        exp_data = flash_mem(exp_addr);
        txns0    = fl_txns;
        i_spi_ce  = 1'b1;
        i_rw      = 1'b1;
        i_address = addr;
        #1 chk("mrdy_drop", o_mrdy, 1'b0);
        n = 0; mrdy_low = 0; first_rise = 0; done = 1'b0;
        while (!done && n < 4000) begin
            @(negedge i_clk);
            n++;
            if (n == 1)
                chk("first_bit", {o_spi_cs_n, o_spi_oe, o_spi_sck, o_spi_mosi},
                    {1'b0, 1'b1, 1'b0, EXP_OPCODE[7]});
            if (!o_mrdy) mrdy_low++;
            if (o_spi_sck && first_rise == 0) first_rise = n;
            if (o_data_valid) done = 1'b1;
            if (n == drop_at) i_spi_ce = 1'b0;
        end
        chk("timeout", done, 1'b1);
        chk("latency", n, EXP_LAT);
        chk("data", o_data, exp_data);
        chk("mrdy_low", mrdy_low, EXP_LAT - 1);
        chk("first_rise", first_rise, 1 + CLK_DIV);
        chk("done_pins", {o_spi_cs_n, o_spi_oe, o_spi_sck, o_mrdy}, 4'b1001);
        chk("opcode", fl_hdr[31:24], EXP_OPCODE);
        chk("address", fl_hdr[23:0], exp_addr);
        chk("sck_count", fl_rises, TOTAL_BITS);
        chk("mosi_zero", fl_mosi_bad, 0);
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            if (o_data_valid || !o_mrdy || !o_spi_cs_n || o_spi_oe) extra++;
        end
        chk("held_quiet", extra, 0);
        chk("one_txn", fl_txns - txns0, 1);
        chk("data_hold", o_data, exp_data);
        i_spi_ce = 1'b0;
        i_rw     = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int bad, txns0, n, drop;
        i_reset_n = 1'b0;
        i_spi_ce  = 1'b0;
        i_rw      = 1'b1;
        i_address = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_pins", {o_spi_cs_n, o_spi_sck, o_spi_mosi, o_spi_oe, o_data_valid, o_mrdy},
            6'b100001);
        chk("rst_data", o_data, 8'h00);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Writes into the window must never start a transfer.
        txns0 = fl_txns; bad = 0;
        i_spi_ce = 1'b1; i_rw = 1'b0;
        repeat (200) begin
            i_address = 16'($urandom);
            @(negedge i_clk);
            if (o_mrdy !== 1'b1 || o_spi_cs_n !== 1'b1 || o_spi_oe !== 1'b0) bad++;
        end
        chk("write_ignored", bad, 0);
        chk("write_no_txn", fl_txns - txns0, 0);
        i_spi_ce = 1'b0;
        @(negedge i_clk);

        // Held select for 400 cycles, then the window wrap case.
        do_read(16'h2123, 0, 400);
        @(negedge i_clk);
        do_read(16'h2FFF, 0, 1);
        @(negedge i_clk);
        do_read(16'h20FF, 0, 3);
        repeat (2) @(negedge i_clk);

        for (int k = 0; k < 12; k++) begin
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, EXP_LAT - 2)) : 0;
            do_read(16'($urandom), drop, int'($urandom_range(1, 20)));
            repeat ($urandom_range(1, 3)) @(negedge i_clk);
        end

        // Reset while the address is being shifted out.
        txns0 = fl_txns;
        salt = 8'($urandom);
        i_spi_ce = 1'b1; i_rw = 1'b1; i_address = 16'($urandom);
        @(negedge i_clk);
        n = 1;
        while (fl_rises < 12 && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        chk("rst_reach_addr", (n < 1000), 1'b1);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_pins", {o_spi_cs_n, o_spi_sck, o_spi_mosi, o_spi_oe, o_data_valid, o_mrdy},
            6'b100001);
        chk("midrst_data", o_data, 8'h00);
        @(negedge i_clk);
        chk("midrst_mrdy_held", o_mrdy, 1'b1);
        i_spi_ce = 1'b0;
        i_reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_data_valid || !o_spi_cs_n) bad++;
        end
        chk("midrst_no_valid", bad, 0);
        chk("midrst_one_txn", fl_txns - txns0, 1);
        do_read(16'h2A5A, 0, 2);
        @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
